pipeline_stall_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the enable and bubble-insert controls of the PC, F/D, D/X, X/M and M/W pipeline latches. It detects load-use hazards and squashes wrong-path instructions on taken branches. It also sequences the multi-cycle multiply/divide unit with a start/ready handshake and a timeout counter.

---
 rtl/pipeline_stall_ctrl_if.sv | 37 +++
 rtl/pipeline_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush controller.
// master = datapath side (presents instructions and status, consumes controls);
// slave  = controller side.
interface pipeline_stall_ctrl_if;
    logic [31:0] ir_fd;
    logic [31:0] ir_dx;
    logic        branch_taken;
    logic        md_ready;

    logic        en_pc;
    logic        en_fd;
    logic        en_dx;
    logic        en_xm;
    logic        en_mw;
    logic        bubble_fd;
    logic        bubble_dx;
    logic        bubble_xm;
    logic        md_start_mult;
    logic        md_start_div;
    logic        md_sel;
    logic        md_exc;
    logic        md_busy;

    modport master (
        output ir_fd, ir_dx, branch_taken, md_ready,
        input  en_pc, en_fd, en_dx, en_xm, en_mw,
        input  bubble_fd, bubble_dx, bubble_xm,
        input  md_start_mult, md_start_div, md_sel, md_exc, md_busy
    );

    modport slave (
        input  ir_fd, ir_dx, branch_taken, md_ready,
        output en_pc, en_fd, en_dx, en_xm, en_mw,
        output bubble_fd, bubble_dx, bubble_xm,
        output md_start_mult, md_start_div, md_sel, md_exc, md_busy
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use stalls, taken-branch
// squashing, and start/wait/timeout sequencing of the multi-cycle mul/div unit.
// All controls are combinational from the registered state/counter and the current inputs.
module pipeline_stall_ctrl #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic                  clk,
    input  logic                  clr,
    pipeline_stall_ctrl_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    // Last WAIT count before the op is abandoned (cnt starts at 0 in the first WAIT cycle).
    localparam logic [5:0] CNT_LAST = 6'(MD_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;

    // Instruction field decode
    logic [4:0]  op_fd, rd_fd, rs_fd, rt_fd;
    logic [4:0]  op_dx, rd_dx, alu_dx;
    logic        dx_mul, dx_div, fd_rtype, fd_rd_src, lu_hazard;
    logic        unused_ir_bits;

    assign op_fd  = bus.ir_fd[31:27];
    assign rd_fd  = bus.ir_fd[26:22];
    assign rs_fd  = bus.ir_fd[21:17];
    assign rt_fd  = bus.ir_fd[16:12];
    assign op_dx  = bus.ir_dx[31:27];
    assign rd_dx  = bus.ir_dx[26:22];
    assign alu_dx = bus.ir_dx[6:2];

    // Fields the controller never looks at.
    assign unused_ir_bits = ^{bus.ir_fd[11:0], bus.ir_dx[21:7], bus.ir_dx[1:0]};

    assign dx_mul    = (op_dx == OP_RTYPE) && (alu_dx == ALU_MUL);
    assign dx_div    = (op_dx == OP_RTYPE) && (alu_dx == ALU_DIV);
    assign fd_rtype  = (op_fd == OP_RTYPE);
    // Store, compare-branches and jr read rd as a source operand.
    assign fd_rd_src = (op_fd == OP_SW) || (op_fd == OP_BNE) ||
                       (op_fd == OP_BLT) || (op_fd == OP_JR);

    assign lu_hazard = (op_dx == OP_LW) && (rd_dx != 5'd0) &&
                       ((rd_dx == rs_fd) ||
                        (fd_rtype && (rd_dx == rt_fd)) ||
                        (fd_rd_src && (rd_dx == rd_fd)));

    logic en_pc, en_fd, en_dx, en_xm, en_mw;
    logic bubble_fd, bubble_dx, bubble_xm;
    logic md_start_mult, md_start_div, md_sel, md_exc, md_busy;

    // Control outputs and next state, in priority order: clr, mul/div, branch, load-use.
    always_comb begin
        en_pc         = 1'b0;
        en_fd         = 1'b0;
        en_dx         = 1'b0;
        en_xm         = 1'b0;
        en_mw         = 1'b0;
        bubble_fd     = 1'b0;
        bubble_dx     = 1'b0;
        bubble_xm     = 1'b0;
        md_start_mult = 1'b0;
        md_start_div  = 1'b0;
        md_sel        = 1'b0;
        md_exc        = 1'b0;
        md_busy       = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;

        if (clr) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end else if (state_q == WAIT) begin
            md_busy = 1'b1;
            if (bus.md_ready || (cnt_q == CNT_LAST)) begin
                // Release: the mul/div (or its abandoned result) moves into X/M.
                {en_pc, en_fd, en_dx, en_xm, en_mw} = 5'b11111;
                md_sel  = 1'b1;
                md_exc  = ~bus.md_ready;
                state_d = IDLE;
                cnt_d   = 6'd0;
            end else begin
                en_xm     = 1'b1;
                en_mw     = 1'b1;
                bubble_xm = 1'b1;
                cnt_d     = cnt_q + 6'd1;
            end
        end else if (dx_mul || dx_div) begin
            md_start_mult = dx_mul;
            md_start_div  = dx_div;
            en_xm         = 1'b1;
            en_mw         = 1'b1;
            bubble_xm     = 1'b1;
            state_d       = WAIT;
            cnt_d         = 6'd0;
        end else if (bus.branch_taken) begin
            {en_pc, en_fd, en_dx, en_xm, en_mw} = 5'b11111;
            bubble_fd = 1'b1;
            bubble_dx = 1'b1;
        end else if (lu_hazard) begin
            // Hold PC and F/D one cycle; the lw drains into X/M behind a bubble.
            en_dx     = 1'b1;
            en_xm     = 1'b1;
            en_mw     = 1'b1;
            bubble_dx = 1'b1;
        end else begin
            {en_pc, en_fd, en_dx, en_xm, en_mw} = 5'b11111;
        end
    end

    // State and WAIT counter registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.en_pc         = en_pc;
    assign bus.en_fd         = en_fd;
    assign bus.en_dx         = en_dx;
    assign bus.en_xm         = en_xm;
    assign bus.en_mw         = en_mw;
    assign bus.bubble_fd     = bubble_fd;
    assign bus.bubble_dx     = bubble_dx;
    assign bus.bubble_xm     = bubble_xm;
    assign bus.md_start_mult = md_start_mult;
    assign bus.md_start_div  = md_start_div;
    assign bus.md_sel        = md_sel;
    assign bus.md_exc        = md_exc;
    assign bus.md_busy       = md_busy;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios followed by random traffic.
// Each cycle's expected control vector comes from a cycle-count reference model and is
// queued; a negedge monitor pops and compares against the DUT outputs.
module tb_pipeline_stall_ctrl;
    localparam int TMO = 5;

    // Expected-vector bit masks, msb first:
    // en_pc en_fd en_dx en_xm en_mw bubble_fd bubble_dx bubble_xm start_mult start_div sel exc busy
    localparam logic [12:0] M_PC   = 13'h1000;
    localparam logic [12:0] M_FD   = 13'h0800;
    localparam logic [12:0] M_DX   = 13'h0400;
    localparam logic [12:0] M_XM   = 13'h0200;
    localparam logic [12:0] M_MW   = 13'h0100;
    localparam logic [12:0] M_BFD  = 13'h0080;
    localparam logic [12:0] M_BDX  = 13'h0040;
    localparam logic [12:0] M_BXM  = 13'h0020;
    localparam logic [12:0] M_SM   = 13'h0010;
    localparam logic [12:0] M_SD   = 13'h0008;
    localparam logic [12:0] M_SEL  = 13'h0004;
    localparam logic [12:0] M_EXC  = 13'h0002;
    localparam logic [12:0] M_BUSY = 13'h0001;
    localparam logic [12:0] ALL_EN = M_PC | M_FD | M_DX | M_XM | M_MW;

    typedef struct {
        logic [12:0] v;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if bus_if ();

    pipeline_stall_ctrl #(.MD_TIMEOUT(TMO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    since = 0;        // cycles since the current mul/div was started; 0 = none pending
    int    cyc_no = 0;
    string phase = "reset";

    function automatic logic [31:0] ins(input logic [4:0] op, rd, rs, rt, alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic bit is_mul(input logic [31:0] i);
        return (i[31:27] == 5'd0) && (i[6:2] == 5'd6);
    endfunction

    function automatic bit is_div(input logic [31:0] i);
        return (i[31:27] == 5'd0) && (i[6:2] == 5'd7);
    endfunction

    function automatic bit load_use(input logic [31:0] fd, dx);
        logic [4:0] srcs[$];
        logic [4:0] op;
        logic [4:0] dst;
        dst = dx[26:22];
        op  = fd[31:27];
        if (dx[31:27] != 5'b01000 || dst == 5'd0) return 1'b0;
        srcs.push_back(fd[21:17]);
        if (op == 5'd0) srcs.push_back(fd[16:12]);
        if (op == 5'b00111 || op == 5'b00010 || op == 5'b00110 || op == 5'b00100)
            srcs.push_back(fd[26:22]);
        foreach (srcs[k]) if (srcs[k] == dst) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: what the controls must be this cycle, and the pending count after the edge.
    function automatic void model(input logic c, input logic [31:0] fd, dx,
                                  input logic br, rdy, input int cur,
                                  output logic [12:0] e, output int nxt);
        e   = '0;
        nxt = 0;
        if (c) return;
        if (cur > 0) begin
            if (rdy)             e = ALL_EN | M_SEL | M_BUSY;
            else if (cur == TMO) e = ALL_EN | M_SEL | M_EXC | M_BUSY;
            else begin
                e   = M_XM | M_MW | M_BXM | M_BUSY;
                nxt = cur + 1;
            end
        end else if (is_mul(dx) || is_div(dx)) begin
            e   = M_XM | M_MW | M_BXM | (is_mul(dx) ? M_SM : M_SD);
            nxt = 1;
        end else if (br) begin
            e = ALL_EN | M_BFD | M_BDX;
        end else if (load_use(fd, dx)) begin
            e = M_DX | M_XM | M_MW | M_BDX;
        end else begin
            e = ALL_EN;
        end
    endfunction

    task automatic cyc(input logic c, input logic [31:0] fd, dx, input logic br, rdy);
        exp_t x;
        int   nxt;
        clr                 = c;
        bus_if.ir_fd        = fd;
        bus_if.ir_dx        = dx;
        bus_if.branch_taken = br;
        bus_if.md_ready     = rdy;
        model(c, fd, dx, br, rdy, since, x.v, nxt);
        x.tag = phase;
        exp_q.push_back(x);
        since = nxt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ins();
        int k;
        logic [4:0] a, b, d;
        logic [31:0] r;
        k = $urandom_range(0, 9);
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        case (k)
            0, 1:    r = ins(5'b01000, a, b, d, 5'($urandom));
            2:       r = ins(5'b00000, a, b, d, 5'd6);
            3:       r = ins(5'b00000, a, b, d, 5'd7);
            4, 5:    r = ins(5'b00000, a, b, d, 5'($urandom_range(0, 5)));
            6:       r = ins(5'b00111, a, b, d, 5'($urandom));
            7:       r = ins(($urandom_range(0, 1) != 0) ? 5'b00010 : 5'b00110, a, b, d, 5'($urandom));
            8:       r = ins(5'b00100, a, b, d, 5'($urandom));
            default: r = ins(5'($urandom), a, b, d, 5'($urandom));
        endcase
        r[11:7] = 5'($urandom);
        r[1:0]  = 2'($urandom);
        return r;
    endfunction

    // Monitor: one comparison per cycle the bench has an expectation for.
    logic [12:0] act;
    exp_t        got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            act = {bus_if.en_pc, bus_if.en_fd, bus_if.en_dx, bus_if.en_xm, bus_if.en_mw,
                   bus_if.bubble_fd, bus_if.bubble_dx, bus_if.bubble_xm,
                   bus_if.md_start_mult, bus_if.md_start_div,
                   bus_if.md_sel, bus_if.md_exc, bus_if.md_busy};
            total++;
            if (act !== got.v) begin
                bad++;
                $display("FAIL %s cycle %0d: controls actual=%b required=%b",
                         got.tag, cyc_no, act, got.v);
            end
            cyc_no++;
        end
    end

    initial begin
        logic [31:0] nop, mul, dv, lw5, lw0, add_dep, add_r0;
        nop     = 32'h0;
        mul     = ins(5'b00000, 5'd3, 5'd1, 5'd2, 5'd6);
        dv      = ins(5'b00000, 5'd4, 5'd1, 5'd2, 5'd7);
        lw5     = ins(5'b01000, 5'd5, 5'd6, 5'd0, 5'd0);
        lw0     = ins(5'b01000, 5'd0, 5'd6, 5'd0, 5'd0);
        add_dep = ins(5'b00000, 5'd1, 5'd5, 5'd2, 5'd0);
        add_r0  = ins(5'b00000, 5'd1, 5'd0, 5'd2, 5'd0);

        bus_if.ir_fd = nop; bus_if.ir_dx = mul;
        bus_if.branch_taken = 1'b0; bus_if.md_ready = 1'b0;
        @(posedge clk); #1;

        phase = "reset_hold";
        repeat (3) cyc(1'b1, nop, mul, 1'b1, 1'b1);
        phase = "mul_ready_k4";
        cyc(1'b0, nop, mul, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, nop, mul, 1'b0, 1'b0);
        cyc(1'b0, nop, mul, 1'b0, 1'b1);
        cyc(1'b0, nop, nop, 1'b0, 1'b1);

        phase = "div_timeout";
        cyc(1'b0, nop, dv, 1'b0, 1'b0);
        repeat (TMO) cyc(1'b0, nop, dv, 1'b0, 1'b0);
        cyc(1'b0, nop, nop, 1'b0, 1'b0);

        phase = "ready_on_timeout";
        cyc(1'b0, nop, mul, 1'b0, 1'b0);
        repeat (TMO - 1) cyc(1'b0, nop, mul, 1'b0, 1'b0);
        cyc(1'b0, nop, mul, 1'b0, 1'b1);
        cyc(1'b0, nop, nop, 1'b0, 1'b0);

        phase = "load_use";
        cyc(1'b0, add_dep, lw5, 1'b0, 1'b0);
        cyc(1'b0, nop, add_dep, 1'b0, 1'b0);
        phase = "load_use_r0";
        cyc(1'b0, add_r0, lw0, 1'b0, 1'b0);

        phase = "branch";
        cyc(1'b0, add_dep, nop, 1'b1, 1'b0);
        phase = "branch_vs_mul";
        cyc(1'b0, add_dep, mul, 1'b1, 1'b0);
        cyc(1'b0, add_dep, mul, 1'b1, 1'b1);

        phase = "back_to_back";
        cyc(1'b0, nop, mul, 1'b0, 1'b0);
        cyc(1'b0, nop, mul, 1'b0, 1'b1);
        cyc(1'b0, nop, dv, 1'b0, 1'b0);
        cyc(1'b0, nop, dv, 1'b0, 1'b1);

        phase = "clr_in_wait";
        cyc(1'b0, nop, mul, 1'b0, 1'b0);
        cyc(1'b0, nop, mul, 1'b0, 1'b0);
        cyc(1'b1, nop, mul, 1'b0, 1'b0);
        cyc(1'b0, nop, nop, 1'b0, 1'b0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                rand_ins(), rand_ins(),
                ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 35));
        end

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending expectations actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
